alu_cpu_param: RTL
==================

# alu_cpu_param

Parametrised, multi-cycle successor to the 8-bit ALU CPU.
- Holds a loadable program memory of {opcode, operand A, operand B} instructions and executes them in sequence.
- Adds iterative multiply, a halt instruction, overflow and zero flags, and an optional step handshake.
- Sits between the instruction loader and the display/monitor logic; the monitor advances execution with next_out.

## Interface
- WIDTH, 8: operand/result width in bits (≥4).
- PC_WIDTH, 8: program counter width.
- DEPTH, 256: program memory entries (≤2^PC_WIDTH).
- STEP_MODE, 1: 1 = hold each result until a next_out rising edge; 0 = free-run.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-low reset.
- load_en  input  1  write one instruction to program memory.
- load_addr  input  PC_WIDTH  write address.
- load_data  input  4+2*WIDTH  instruction {opcode[3:0], A, B}.
- start  input  1  begin execution at pc 0.
- next_out  input  1  step request; only its rising edge is used.
- opcode  output  8  zero-extended opcode of the current instruction.
- operand_A_out, operand_B_out  output  WIDTH  current operands.
- result_out_cpu  output  WIDTH  result.
- carry_out_cpu, borrow_out_cpu, overflow_out  output  1  flags.
- data_out  output  1  zero flag (result == 0).
- result_ready  output  1  result and flags valid.
- pc_out  output  PC_WIDTH  address of the current instruction.

## Operation
- FSM states: IDLE, FETCH, EXEC, HOLD, HALT.
  - IDLE: start → pc=0, FETCH.
  - FETCH: registered memory read; go to EXEC.
  - EXEC: single-cycle ops finish in 1 cycle; MUL takes WIDTH cycles (shift-add); then HOLD, or HALT for opcode F.
  - HOLD: result_ready=1.
    - STEP_MODE=1: stay until a next_out rising edge, then pc+1 and FETCH.
    - STEP_MODE=0: stay one cycle, then pc+1 and FETCH.
  - HALT: outputs frozen, result_ready=0; start → pc=0, FETCH.
- Opcodes (A, B unsigned unless noted):
  - 0 ADD: result = A+B; carry = bit WIDTH of the sum; overflow = signed overflow.
  - 1 SUB: result = A−B; borrow = A<B unsigned; overflow = signed overflow.
  - 2 AND, 3 OR, 4 XOR.
  - 5 NOT A.
  - 6 SHL: A<<1; carry = A[MSB].
  - 7 SAR: arithmetic right shift of A by 1; carry = A[0].
  - 8 MUL: result = low WIDTH bits of A*B; carry = 1 if the high half is nonzero.
  - 9 CMP: like SUB, but result_out_cpu keeps its previous value.
  - F HALT.
  - Others: NOP, result 0.
- Flags not defined for an opcode are 0. data_out is recomputed from result_out_cpu on every update.
- Operand outputs, opcode and pc_out update on EXEC entry; result and flags update on HOLD entry.
- pc wraps from DEPTH−1 to 0.
- Program memory:
  - load_en writes only in IDLE or HALT; ignored in other states.
  - Memory is not cleared by reset.
- next_out edge detector: 1-cycle registered compare, reset to 0. Edges outside HOLD are discarded, not queued.

## Timing
- Reset (async, rst low): every output 0; state IDLE; pc 0; edge register 0; MUL datapath cleared. Reset mid-MUL or in HOLD abandons the instruction.
- start sampled in IDLE/HALT only; ignored elsewhere.
- Latency from start (cycle 0):
  - FETCH in cycle 1, EXEC in cycle 2.
  - Single-cycle op: result_ready=1 from cycle 3.
  - MUL: result_ready=1 from cycle 2+WIDTH.
- STEP_MODE=1: a next_out rising edge seen at clock N drops result_ready at N+1, with FETCH at N+1.
- load_en and start in the same cycle: the write completes and execution starts; a fetch of that address returns the new data.

## Test plan
- ADD: load [0]={0,0x7F,0x01}, [1]={F,0,0}; start → result 0x80, carry 0, overflow 1, data_out 0, result_ready in cycle 3.
- SUB/CMP: [0]={1,0x03,0x05}, [1]={9,0x05,0x05} → step 1: result 0xFE, borrow 1; after a next_out edge: result still 0xFE, data_out 0, borrow 0, pc_out 1.
- MUL: [0]={8,0x10,0x20} → result 0x00, carry 1, data_out 1; result_ready asserts exactly WIDTH+2 cycles after start. A second run with {8,0x0C,0x0B} gives 0x84, carry 0.
- Step handshake: hold next_out high across HOLD entry → no advance; only a low→high transition advances pc. STEP_MODE=0 runs ADD×3 + HALT back-to-back with no next_out toggles.
- Wrap/halt: DEPTH=4, no HALT → pc_out sequence 0,1,2,3,0. A HALT at 2 freezes pc_out=2 with result_ready=0; load_en ignored during EXEC and accepted in HALT.
- Reset mid-MUL: drop rst at EXEC cycle 3 → all outputs 0 immediately, state IDLE; program memory intact; a restart gives the correct product.

Source files
------------

// File: rtl/alu_cpu_param.sv
// Multi-cycle parametrised ALU CPU: loadable program memory, shift-add MUL, HALT, optional step handshake.
// Latency: result 3 cycles after start (2+WIDTH for MUL); STEP_MODE=1 holds each result until a next_out rising edge.
module alu_cpu_param #(
   parameter int WIDTH     = 8,
   parameter int PC_WIDTH  = 8,
   parameter int DEPTH     = 256,
   parameter int STEP_MODE = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_en,
   input  logic [PC_WIDTH-1:0]     load_addr,
   input  logic [4+2*WIDTH-1:0]    load_data,
   input  logic                    start,
   input  logic                    next_out,
   output logic [7:0]              opcode,
   output logic [WIDTH-1:0]        operand_A_out,
   output logic [WIDTH-1:0]        operand_B_out,
   output logic [WIDTH-1:0]        result_out_cpu,
   output logic                    carry_out_cpu,
   output logic                    borrow_out_cpu,
   output logic                    overflow_out,
   output logic                    data_out,
   output logic                    result_ready,
   output logic [PC_WIDTH-1:0]     pc_out
);
   localparam int IW  = 4 + 2*WIDTH;
   localparam int CW  = $clog2(WIDTH) + 1;
   localparam int MSB = WIDTH - 1;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HOLD, S_HALT} state_t;

   logic [IW-1:0]        r_mem [DEPTH];
   state_t               r_state;
   logic [PC_WIDTH-1:0]  r_pc;
   logic                 r_next_d;
   logic [2*WIDTH-1:0]   r_mul_acc;
   logic [2*WIDTH-1:0]   r_mul_a;
   logic [WIDTH-1:0]     r_mul_b;
   logic [CW-1:0]        r_mul_cnt;

   logic                 w_load_ok;
   logic                 w_next_rise;
   logic [PC_WIDTH-1:0]  w_pc_next;
   logic [IW-1:0]        w_instr;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_diff;
   logic [2*WIDTH-1:0]   w_mul_next;
   logic [WIDTH-1:0]     w_res;
   logic                 w_carry;
   logic                 w_borrow;
   logic                 w_ovf;

   assign w_load_ok   = load_en && (r_state == S_IDLE || r_state == S_HALT);
   assign w_next_rise = next_out && !r_next_d;
   assign w_pc_next   = (r_pc == PC_WIDTH'(DEPTH-1)) ? '0 : r_pc + PC_WIDTH'(1);
   assign w_instr     = r_mem[r_pc];
   assign w_sum       = {1'b0, operand_A_out} + {1'b0, operand_B_out};
   assign w_diff      = {1'b0, operand_A_out} - {1'b0, operand_B_out};
   assign w_mul_next  = r_mul_b[0] ? r_mul_acc + r_mul_a : r_mul_acc;

   // Program memory has no reset so a loaded program survives rst.
   always_ff @(posedge clk) begin
      if (w_load_ok) r_mem[load_addr] <= load_data;
   end

   always_comb begin
      w_res    = '0;
      w_carry  = 1'b0;
      w_borrow = 1'b0;
      w_ovf    = 1'b0;
      case (opcode[3:0])
         4'h0: begin
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
            w_ovf   = (operand_A_out[MSB] == operand_B_out[MSB]) && (w_sum[MSB] != operand_A_out[MSB]);
         end
         4'h1, 4'h9: begin
            // CMP shares SUB's flags but leaves the visible result untouched
            w_res    = (opcode[3:0] == 4'h9) ? result_out_cpu : w_diff[WIDTH-1:0];
            w_borrow = w_diff[WIDTH];
            w_ovf    = (operand_A_out[MSB] != operand_B_out[MSB]) && (w_diff[MSB] != operand_A_out[MSB]);
         end
         4'h2: w_res = operand_A_out & operand_B_out;
         4'h3: w_res = operand_A_out | operand_B_out;
         4'h4: w_res = operand_A_out ^ operand_B_out;
         4'h5: w_res = ~operand_A_out;
         4'h6: begin
            w_res   = {operand_A_out[MSB-1:0], 1'b0};
            w_carry = operand_A_out[MSB];
         end
         4'h7: begin
            w_res   = {operand_A_out[MSB], operand_A_out[MSB:1]};
            w_carry = operand_A_out[0];
         end
         4'h8: begin
            w_res   = w_mul_next[WIDTH-1:0];
            w_carry = |w_mul_next[2*WIDTH-1:WIDTH];
         end
         default: w_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_pc           <= '0;
         r_next_d       <= 1'b0;
         r_mul_acc      <= '0;
         r_mul_a        <= '0;
         r_mul_b        <= '0;
         r_mul_cnt      <= '0;
         opcode         <= '0;
         operand_A_out  <= '0;
         operand_B_out  <= '0;
         result_out_cpu <= '0;
         carry_out_cpu  <= 1'b0;
         borrow_out_cpu <= 1'b0;
         overflow_out   <= 1'b0;
         data_out       <= 1'b0;
         result_ready   <= 1'b0;
         pc_out         <= '0;
      end else begin
         r_next_d <= next_out;
         case (r_state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  r_pc    <= '0;
                  r_state <= S_FETCH;
               end
            end
            S_FETCH: begin
               opcode        <= {4'b0000, w_instr[IW-1 -: 4]};
               operand_A_out <= w_instr[2*WIDTH-1:WIDTH];
               operand_B_out <= w_instr[WIDTH-1:0];
               pc_out        <= r_pc;
               r_mul_acc     <= '0;
               r_mul_a       <= {{WIDTH{1'b0}}, w_instr[2*WIDTH-1:WIDTH]};
               r_mul_b       <= w_instr[WIDTH-1:0];
               r_mul_cnt     <= '0;
               r_state       <= S_EXEC;
            end
            S_EXEC: begin
               if (opcode[3:0] == 4'hF) begin
                  r_state <= S_HALT;
               end else if (opcode[3:0] == 4'h8 && r_mul_cnt != CW'(WIDTH-1)) begin
                  r_mul_acc <= w_mul_next;
                  r_mul_a   <= r_mul_a << 1;
                  r_mul_b   <= r_mul_b >> 1;
                  r_mul_cnt <= r_mul_cnt + CW'(1);
               end else begin
                  result_out_cpu <= w_res;
                  carry_out_cpu  <= w_carry;
                  borrow_out_cpu <= w_borrow;
                  overflow_out   <= w_ovf;
                  data_out       <= (w_res == '0);
                  result_ready   <= 1'b1;
                  r_state        <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (STEP_MODE == 0 || w_next_rise) begin
                  result_ready <= 1'b0;
                  r_pc         <= w_pc_next;
                  r_state      <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
